// File: rtl/controller_rom_loader_if.sv
// rtl/controller_rom_loader_if.sv - byte download stream, control and RAM write port bundle
// The loader attaches through the slave modport; the download front end and RAM side use master.
interface controller_rom_loader_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_data;
  logic                  in_last;
  logic                  mem_we;
  logic [3:0]            mem_bytesel;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_d;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [ADDR_WIDTH+1:0] byte_count;

  modport slave (
    input  start, abort, base_addr, in_valid, in_data, in_last,
    output in_ready, mem_we, mem_bytesel, mem_addr, mem_d, busy, done, overflow, byte_count
  );

  modport master (
    output start, abort, base_addr, in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_bytesel, mem_addr, mem_d, busy, done, overflow, byte_count
  );
endinterface

// File: rtl/controller_rom_loader.sv
// rtl/controller_rom_loader.sv - packs a byte stream big-endian into byte-enabled 32-bit RAM writes
// Lane 0 is the most significant byte; a trailing partial word is written with only its filled lanes.
module controller_rom_loader #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  controller_rom_loader_if.slave   bus
);
  localparam int CW = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           pack_q, pack_d;
  logic                  full_q, full_d;
  logic                  overflow_q, overflow_d;
  logic [CW-1:0]         byte_count_q, byte_count_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_bytesel_q, mem_bytesel_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_d_q, mem_d_d;
  logic                  busy_q, done_q;

  logic        accept;
  logic [31:0] lane_word;
  logic [31:0] word;
  logic [3:0]  lane_mask;

  assign accept = bus.in_valid && busy_q;

  always_comb begin
    lane_word = 32'h0;
    lane_mask = 4'h0;
    case (lane_q)
      2'd0: begin lane_word = {bus.in_data, 24'h0};       lane_mask = 4'b0001; end
      2'd1: begin lane_word = {8'h0, bus.in_data, 16'h0}; lane_mask = 4'b0011; end
      2'd2: begin lane_word = {16'h0, bus.in_data, 8'h0}; lane_mask = 4'b0111; end
      default: begin lane_word = {24'h0, bus.in_data};    lane_mask = 4'b1111; end
    endcase
    word = pack_q | lane_word;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    lane_d        = lane_q;
    pack_d        = pack_q;
    full_d        = full_q;
    overflow_d    = overflow_q;
    byte_count_d  = byte_count_q;
    mem_we_d      = 1'b0;
    mem_bytesel_d = mem_bytesel_q;
    mem_addr_d    = mem_addr_q;
    mem_d_d       = mem_d_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d      = ST_LOAD;
          ptr_d        = bus.base_addr;
          lane_d       = 2'd0;
          pack_d       = 32'h0;
          full_d       = 1'b0;
          overflow_d   = 1'b0;
          byte_count_d = '0;
        end
      end
      ST_LOAD: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          pack_d  = 32'h0;
        end else if (accept) begin
          if (byte_count_q != '1) begin
            byte_count_d = byte_count_q + CW'(1);
          end
          lane_d = lane_q + 2'd1;
          // Once the top word has been written, later bytes are only counted.
          if (full_q) begin
            overflow_d = 1'b1;
          end else if (lane_q == 2'd3 || bus.in_last) begin
            mem_we_d      = 1'b1;
            mem_bytesel_d = lane_mask;
            mem_addr_d    = ptr_q;
            mem_d_d       = word;
            ptr_d         = ptr_q + ADDR_WIDTH'(1);
            pack_d        = 32'h0;
            if (ptr_q == '1) begin
              full_d = 1'b1;
            end
          end else begin
            pack_d = word;
          end
          if (bus.in_last) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      lane_q        <= 2'd0;
      pack_q        <= 32'h0;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
      byte_count_q  <= '0;
      mem_we_q      <= 1'b0;
      mem_bytesel_q <= 4'h0;
      mem_addr_q    <= '0;
      mem_d_q       <= 32'h0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      lane_q        <= lane_d;
      pack_q        <= pack_d;
      full_q        <= full_d;
      overflow_q    <= overflow_d;
      byte_count_q  <= byte_count_d;
      mem_we_q      <= mem_we_d;
      mem_bytesel_q <= mem_bytesel_d;
      mem_addr_q    <= mem_addr_d;
      mem_d_q       <= mem_d_d;
      busy_q        <= (state_d == ST_LOAD);
      done_q        <= (state_d == ST_DONE);
    end
  end

  assign bus.in_ready    = busy_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.overflow    = overflow_q;
  assign bus.byte_count  = byte_count_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_bytesel = mem_bytesel_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_d       = mem_d_q;
endmodule

// File: tb/tb_controller_rom_loader.sv
// tb/tb_controller_rom_loader.sv - scoreboard bench for controller_rom_loader
// Expected RAM writes are queued by the stimulus and popped by a negedge monitor.
module tb_controller_rom_loader;
  localparam int AW = 15;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [3:0]    sel;
    logic [31:0]   d;
  } wr_t;

  logic clk;
  logic reset_n;
  int   pass_cnt;
  int   total_cnt;
  wr_t  exp_q[$];

  controller_rom_loader_if #(.ADDR_WIDTH(AW)) ifc ();

  controller_rom_loader #(.ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n && ifc.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: addr 0x%0h sel 0x%0h d 0x%0h, expected no write",
                 ifc.mem_addr, ifc.mem_bytesel, ifc.mem_d);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write", {13'h0, ifc.mem_addr, ifc.mem_bytesel, ifc.mem_d}, {13'h0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [3:0] s, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.sel  = s;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    ifc.start     = 1'b1;
    ifc.base_addr = base;
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = b;
    ifc.in_last  = last;
    while (ifc.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (ifc.in_ready !== 1'b1) chk("accept_timeout", 64'd0, 64'd1);
    tick();
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic check_end(input string tag, input logic dn, input logic ov, input int cnt);
    tick();
    chk({tag, "_done"}, 64'(ifc.done), 64'(dn));
    chk({tag, "_busy"}, 64'(ifc.busy), 64'd0);
    chk({tag, "_in_ready"}, 64'(ifc.in_ready), 64'd0);
    chk({tag, "_overflow"}, 64'(ifc.overflow), 64'(ov));
    chk({tag, "_byte_count"}, 64'(ifc.byte_count), 64'(cnt));
    chk({tag, "_mem_we_low"}, 64'(ifc.mem_we), 64'd0);
    chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(ifc.in_ready), 64'd0);
    chk({tag, "_mem_we"}, 64'(ifc.mem_we), 64'd0);
    chk({tag, "_bytesel"}, 64'(ifc.mem_bytesel), 64'd0);
    chk({tag, "_addr"}, 64'(ifc.mem_addr), 64'd0);
    chk({tag, "_d"}, 64'(ifc.mem_d), 64'd0);
    chk({tag, "_busy"}, 64'(ifc.busy), 64'd0);
    chk({tag, "_done"}, 64'(ifc.done), 64'd0);
    chk({tag, "_overflow"}, 64'(ifc.overflow), 64'd0);
    chk({tag, "_byte_count"}, 64'(ifc.byte_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s2 [8];
    pass_cnt      = 0;
    total_cnt     = 0;
    reset_n       = 1'b0;
    ifc.start     = 1'b0;
    ifc.abort     = 1'b0;
    ifc.base_addr = '0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = 8'h0;
    ifc.in_last   = 1'b0;
    #13;
    check_reset_outputs("por");
    tick();
    reset_n = 1'b1;
    tick();

    // Two full words; a start pulse mid-load must be ignored.
    s2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    push_exp(15'h0010, 4'hF, 32'h11223344);
    push_exp(15'h0011, 4'hF, 32'h55667788);
    do_start(15'h0010);
    chk("start_busy", 64'(ifc.busy), 64'd1);
    chk("start_in_ready", 64'(ifc.in_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        ifc.start     = 1'b1;
        ifc.base_addr = 15'h0555;
      end
      send_byte(s2[i], i == 7);
      ifc.start = 1'b0;
    end
    check_end("two_words", 1'b1, 1'b0, 8);

    // Partial trailing word, started from DONE.
    push_exp(15'h0020, 4'b0111, 32'hAABBCC00);
    do_start(15'h0020);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    check_end("partial", 1'b1, 1'b0, 3);

    // Top of RAM: one write, then dropped bytes raise overflow.
    push_exp(15'h7FFF, 4'hF, 32'h01020304);
    do_start(15'h7FFF);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), i == 6);
    check_end("wrap", 1'b1, 1'b1, 6);

    // Restart from DONE with gaps; flags clear on start.
    push_exp(15'h0100, 4'hF, 32'h01020304);
    do_start(15'h0100);
    chk("restart_done_clr", 64'(ifc.done), 64'd0);
    chk("restart_ovf_clr", 64'(ifc.overflow), 64'd0);
    chk("restart_count_clr", 64'(ifc.byte_count), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick();
      send_byte(8'(i), i == 4);
    end
    check_end("gaps", 1'b1, 1'b0, 4);

    // Abort with a partial word: no write, count retained.
    do_start(15'h0030);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    ifc.abort = 1'b1;
    ifc.start = 1'b1;
    tick();
    ifc.abort = 1'b0;
    ifc.start = 1'b0;
    check_end("abort", 1'b0, 1'b0, 2);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_accept", 64'(ifc.in_ready), 64'd0);
    end
    ifc.in_valid = 1'b0;
    chk("abort_count_held", 64'(ifc.byte_count), 64'd2);

    // Asynchronous reset mid-load with a partial word.
    do_start(15'h0040);
    send_byte(8'h99, 1'b0);
    send_byte(8'hAA, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    reset_n = 1'b1;
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_accept", 64'(ifc.in_ready), 64'd0);
    end
    ifc.in_valid = 1'b0;
    chk("post_rst_count", 64'(ifc.byte_count), 64'd0);
    chk("post_rst_pending", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/controller_rom_loader.md
# controller_rom_loader

Download engine that fills the control CPU's byte-laned 32-bit program/data RAM from an 8-bit byte stream (host/SPI download path). It packs incoming bytes big-endian into 32-bit words and issues single-cycle byte-enabled write commands to the RAM port: lane 0 is d[31:24]/bytesel[0] … lane 3 is d[7:0]/bytesel[3]. It sits between the download front end and the RAM write port; the CPU read port is untouched.

## Interface
- ADDR_WIDTH, 15, word-address width of the target RAM; must match the RAM instance.

- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a download at base_addr (honoured in IDLE and DONE only)
- abort  in  1  one-cycle pulse; cancels a download in progress
- base_addr  in  ADDR_WIDTH  first word address, sampled on accepted start
- in_valid  in  1  in_data/in_last valid
- in_ready  out  1  byte accepted when in_valid & in_ready
- in_data  in  8  download byte
- in_last  in  1  marks final byte of the image
- mem_we  out  1  write strobe to RAM, one cycle per write
- mem_bytesel  out  4  lane enables, bit k = lane k
- mem_addr  out  ADDR_WIDTH  word address of the write
- mem_d  out  32  write data, lane k at d[31-8k -: 8]
- busy  out  1  high in LOAD
- done  out  1  high in DONE
- overflow  out  1  sticky: bytes were dropped past top of RAM
- byte_count  out  ADDR_WIDTH+2  bytes accepted in current/last download

## Operation
- States: IDLE, LOAD, DONE. Reset -> IDLE.
- IDLE/DONE: start -> LOAD; word pointer <= base_addr, lane <= 0, packer <= 0, byte_count <= 0, overflow <= 0, done <= 0.
- LOAD: in_ready = 1. Each accepted byte goes to lane `lane` of the packer, byte_count += 1, lane += 1 (mod 4).
- Word complete (byte accepted in lane 3): issue write with bytesel 4'hF, addr = pointer, d = packed word; pointer += 1; packer cleared.
- in_last accepted: if lane < 3, issue partial write with bytesel bits 0..lane set, unfilled lanes of mem_d = 0; either way state -> DONE.
- Wrap: after a write at pointer 2**ADDR_WIDTH-1 a full flag sets; further accepted bytes are counted but produce no writes and set overflow. in_last still ends the download in DONE.
- abort in LOAD -> IDLE; partial packer discarded, no write issued, byte_count and overflow retained, done stays 0. abort outside LOAD ignored.
- start while in LOAD ignored. abort and start in the same cycle in LOAD: abort wins.
- in_valid in IDLE/DONE: in_ready = 0, nothing accepted.
- byte_count saturates at all-ones.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_bytesel 0, mem_addr 0, mem_d 0, busy 0, done 0, overflow 0, byte_count 0.
- All outputs registered. Byte accepted at edge N that completes a word (or carries in_last): mem_we/bytesel/addr/d valid after edge N, held exactly one cycle; RAM writes at edge N+1. mem_we drops at N+1 unless another write is issued.
- Sustained throughput one byte per cycle, no back-pressure in LOAD; back-to-back words give mem_we high one cycle in every four.
- start at edge N: busy/in_ready high after N; first byte acceptable at edge N+1.
- in_last at edge N: done high and busy/in_ready low after N; write (if any) also after N.
- mem_bytesel/mem_addr/mem_d hold last value when mem_we = 0.

## Test plan
- Reset mid-LOAD with a partial word: all outputs return to reset values asynchronously, no write, start needed to resume.
- base_addr 0x0010, bytes 11 22 33 44 55 66 77 88 (last on 88) -> writes {0x0010, F, 0x11223344}, {0x0011, F, 0x55667788}; done=1, byte_count=8.
- base_addr 0x0020, bytes AA BB CC (last on CC) -> one write {0x0020, 4'b0111, 0xAABBCC00}; done=1, byte_count=3.
- base_addr 0x7FFF, 6 bytes 01..06 (last on 06) -> single write {0x7FFF, F, 0x01020304}; no further writes, overflow=1, byte_count=6, done=1.
- Start, bytes DE AD, abort -> no write, state IDLE, done=0, byte_count=2; in_valid afterwards not accepted (in_ready=0).
- In DONE, new start with base_addr 0x0100 and bytes 01 02 03 04 at random in_valid gaps -> one write {0x0100, F, 0x01020304}; done/overflow cleared on start, byte_count restarts from 0.
